// File: rtl/lives_hud_controller.sv
// Lives counter with hit invulnerability and a row of heart slots drawn at the top-left HUD area.
// Heart geometry is combinational; the bitmap ROM downstream provides the pipeline stage.
module lives_hud_controller #(
   parameter int HUD_X         = 16,
   parameter int HUD_Y         = 8,
   parameter int INIT_LIVES    = 3,
   parameter int MAX_LIVES     = 5,
   parameter int INVULN_FRAMES = 90,
   parameter int BLINK_BIT     = 3
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        playerHit,
   input  logic        extraLife,
   input  logic        newGame,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        InsideRectangle,
   output logic [2:0]  livesCount,
   output logic        gameOver,
   output logic        invulnerable
);

   typedef enum logic [1:0] {
      PLAYING   = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   localparam logic [10:0] HUD_X_C   = 11'(HUD_X);
   localparam logic [10:0] HUD_Y_C   = 11'(HUD_Y);
   localparam logic [11:0] HUD_Y_END = 12'(HUD_Y + 32);
   localparam logic [2:0]  INIT_C    = 3'(INIT_LIVES);
   localparam logic [2:0]  MAX_C     = 3'(MAX_LIVES);
   localparam logic [7:0]  INV_C     = 8'(INVULN_FRAMES);

   state_t      state_q, state_d;
   logic [2:0]  lives_q, lives_d;
   logic [7:0]  inv_cnt_q, inv_cnt_d;
   logic        hit_d_q;
   logic        hit_ev;

   assign hit_ev = playerHit & ~hit_d_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q   <= PLAYING;
         lives_q   <= INIT_C;
         inv_cnt_q <= 8'd0;
         hit_d_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         inv_cnt_q <= inv_cnt_d;
         hit_d_q   <= playerHit;
      end
   end

   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      inv_cnt_d = inv_cnt_q;
      if (newGame) begin
         state_d   = PLAYING;
         lives_d   = INIT_C;
         inv_cnt_d = 8'd0;
      end else begin
         case (state_q)
            PLAYING: begin
               if (hit_ev && extraLife) begin
                  // Simultaneous hit and bonus cancel out, but the hit still grants invulnerability.
                  state_d   = INVULN;
                  inv_cnt_d = INV_C;
               end else if (hit_ev) begin
                  if (lives_q <= 3'd1) begin
                     state_d = GAME_OVER;
                     lives_d = 3'd0;
                  end else begin
                     state_d   = INVULN;
                     lives_d   = lives_q - 3'd1;
                     inv_cnt_d = INV_C;
                  end
               end else if (extraLife && (lives_q < MAX_C)) begin
                  lives_d = lives_q + 3'd1;
               end
            end
            INVULN: begin
               if (extraLife && (lives_q < MAX_C)) lives_d = lives_q + 3'd1;
               if (startOfFrame) begin
                  if (inv_cnt_q <= 8'd1) begin
                     state_d   = PLAYING;
                     inv_cnt_d = 8'd0;
                  end else begin
                     inv_cnt_d = inv_cnt_q - 8'd1;
                  end
               end
            end
            GAME_OVER: begin
               lives_d = 3'd0;
            end
            default: begin
               state_d   = PLAYING;
               lives_d   = INIT_C;
               inv_cnt_d = 8'd0;
            end
         endcase
      end
   end

   logic [10:0] rel_x, rel_y;
   logic [5:0]  slot;
   logic        blank;
   logic        in_x, in_y;

   assign rel_x = pixelX - HUD_X_C;
   assign rel_y = pixelY - HUD_Y_C;
   assign slot  = rel_x[10:5];
   assign blank = (state_q == INVULN) && inv_cnt_q[BLINK_BIT];
   assign in_x  = (pixelX >= HUD_X_C) && ({3'b000, slot} < {6'b000000, lives_q});
   assign in_y  = (pixelY >= HUD_Y_C) && ({1'b0, pixelY} < HUD_Y_END);

   assign offsetX         = {6'b000000, rel_x[4:0]};
   assign offsetY         = {6'b000000, rel_y[4:0]};
   assign InsideRectangle = in_x && in_y && !blank;
   assign livesCount      = lives_q;
   assign gameOver        = (state_q == GAME_OVER);
   assign invulnerable    = (state_q == INVULN);

endmodule

// File: tb/tb_lives_hud_controller.sv
// Directed self-checking bench for lives_hud_controller using its default parameters.
module tb_lives_hud_controller;

   logic        clk = 1'b0;
   logic        resetN;
   logic [10:0] pixelX, pixelY;
   logic        startOfFrame, playerHit, extraLife, newGame;
   logic [10:0] offsetX, offsetY;
   logic        InsideRectangle;
   logic [2:0]  livesCount;
   logic        gameOver, invulnerable;

   int checks   = 0;
   int failures = 0;

   lives_hud_controller dut (
      .clk             (clk),
      .resetN          (resetN),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .startOfFrame    (startOfFrame),
      .playerHit       (playerHit),
      .extraLife       (extraLife),
      .newGame         (newGame),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .InsideRectangle (InsideRectangle),
      .livesCount      (livesCount),
      .gameOver        (gameOver),
      .invulnerable    (invulnerable)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sof(input int n);
      for (int i = 0; i < n; i++) begin
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
      end
   endtask

   task automatic hit_pulse();
      playerHit = 1'b1;
      tick();
      playerHit = 1'b0;
      tick();
   endtask

   task automatic new_game();
      newGame = 1'b1;
      tick();
      newGame = 1'b0;
   endtask

   // 3 -> 2 -> 1 lives, each followed by a full invulnerability window
   task automatic reach_one_life();
      new_game();
      hit_pulse();
      sof(90);
      hit_pulse();
      sof(90);
   endtask

   task automatic test_reset();
      resetN = 1'b0; pixelX = 11'd0; pixelY = 11'd0;
      startOfFrame = 1'b0; playerHit = 1'b0; extraLife = 1'b0; newGame = 1'b0;
      tick(); tick();
      checks++;
      if (livesCount !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", livesCount); end
      checks++;
      if (gameOver !== 1'b0 || invulnerable !== 1'b0) begin
         failures++; $display("FAIL reset_flags got go=%b inv=%b exp go=0 inv=0", gameOver, invulnerable);
      end
      checks++;
      if (dut.inv_cnt_q !== 8'd0) begin failures++; $display("FAIL reset_invcnt got=%0d exp=0", dut.inv_cnt_q); end
      resetN = 1'b1;
      tick();
   endtask

   task automatic test_scan();
      int bad = 0;
      for (int y = 0; y < 46; y++) begin
         for (int x = 0; x < 141; x++) begin
            logic exp_in;
            pixelX = 11'(x); pixelY = 11'(y);
            #1;
            exp_in = (x >= 16) && (x < 112) && (y >= 8) && (y < 40);
            checks++;
            if (InsideRectangle !== exp_in) begin
               failures++; bad++;
               if (bad < 10) $display("FAIL scan_inside x=%0d y=%0d got=%b exp=%b", x, y, InsideRectangle, exp_in);
            end
            if (exp_in) begin
               checks++;
               if (offsetX !== 11'((x - 16) % 32) || offsetY !== 11'(y - 8)) begin
                  failures++; bad++;
                  if (bad < 10) $display("FAIL scan_offset x=%0d y=%0d got=%0d,%0d exp=%0d,%0d",
                                         x, y, offsetX, offsetY, (x - 16) % 32, y - 8);
               end
            end
         end
      end
      pixelX = 11'd16; pixelY = 11'd8;
   endtask

   task automatic test_hit_hold();
      playerHit = 1'b1;
      tick();
      checks++;
      if (livesCount !== 3'd2 || invulnerable !== 1'b1 || dut.inv_cnt_q !== 8'd90) begin
         failures++; $display("FAIL hit_first got lives=%0d inv=%b cnt=%0d exp lives=2 inv=1 cnt=90",
                              livesCount, invulnerable, dut.inv_cnt_q);
      end
      for (int i = 0; i < 9; i++) tick();
      playerHit = 1'b0;
      tick();
      checks++;
      if (livesCount !== 3'd2 || dut.inv_cnt_q !== 8'd90) begin
         failures++; $display("FAIL hit_hold got lives=%0d cnt=%0d exp lives=2 cnt=90", livesCount, dut.inv_cnt_q);
      end
      hit_pulse();
      checks++;
      if (livesCount !== 3'd2 || dut.inv_cnt_q !== 8'd90 || invulnerable !== 1'b1) begin
         failures++; $display("FAIL invuln_hit_ignored got lives=%0d cnt=%0d exp lives=2 cnt=90", livesCount, dut.inv_cnt_q);
      end
   endtask

   task automatic test_invuln();
      pixelX = 11'd16; pixelY = 11'd8;
      for (int k = 1; k <= 90; k++) begin
         sof(1);
         if (k == 1) begin
            checks++;
            if (dut.inv_cnt_q !== 8'd89) begin failures++; $display("FAIL invcnt_dec got=%0d exp=89", dut.inv_cnt_q); end
         end
         if (k == 2) begin
            checks++;
            if (InsideRectangle !== 1'b0) begin failures++; $display("FAIL blink_blank cnt=88 got=%b exp=0", InsideRectangle); end
         end
         if (k == 10) begin
            checks++;
            if (InsideRectangle !== 1'b1) begin failures++; $display("FAIL blink_draw cnt=80 got=%b exp=1", InsideRectangle); end
         end
         if (k == 89) begin
            checks++;
            if (invulnerable !== 1'b1) begin failures++; $display("FAIL invuln_89 got=%b exp=1", invulnerable); end
         end
      end
      checks++;
      if (invulnerable !== 1'b0 || dut.inv_cnt_q !== 8'd0 || livesCount !== 3'd2) begin
         failures++; $display("FAIL invuln_exit got inv=%b cnt=%0d lives=%0d exp inv=0 cnt=0 lives=2",
                              invulnerable, dut.inv_cnt_q, livesCount);
      end
   endtask

   task automatic test_extra_sat();
      logic [2:0] exp_l [4];
      exp_l[0] = 3'd4; exp_l[1] = 3'd5; exp_l[2] = 3'd5; exp_l[3] = 3'd5;
      new_game();
      for (int i = 0; i < 4; i++) begin
         extraLife = 1'b1;
         tick();
         extraLife = 1'b0;
         checks++;
         if (livesCount !== exp_l[i]) begin
            failures++; $display("FAIL extra_sat step=%0d got=%0d exp=%0d", i, livesCount, exp_l[i]);
         end
      end
   endtask

   task automatic test_game_over();
      reach_one_life();
      checks++;
      if (livesCount !== 3'd1 || invulnerable !== 1'b0) begin
         failures++; $display("FAIL one_life_setup got lives=%0d inv=%b exp lives=1 inv=0", livesCount, invulnerable);
      end
      hit_pulse();
      pixelX = 11'd16; pixelY = 11'd8; #1;
      checks++;
      if (gameOver !== 1'b1 || livesCount !== 3'd0 || InsideRectangle !== 1'b0) begin
         failures++; $display("FAIL game_over got go=%b lives=%0d in=%b exp go=1 lives=0 in=0",
                              gameOver, livesCount, InsideRectangle);
      end
      extraLife = 1'b1; tick(); extraLife = 1'b0;
      hit_pulse();
      checks++;
      if (gameOver !== 1'b1 || livesCount !== 3'd0) begin
         failures++; $display("FAIL game_over_ignore got go=%b lives=%0d exp go=1 lives=0", gameOver, livesCount);
      end
      newGame = 1'b1; playerHit = 1'b1; extraLife = 1'b1;
      tick();
      newGame = 1'b0; playerHit = 1'b0; extraLife = 1'b0;
      checks++;
      if (gameOver !== 1'b0 || invulnerable !== 1'b0 || livesCount !== 3'd3) begin
         failures++; $display("FAIL new_game got go=%b inv=%b lives=%0d exp go=0 inv=0 lives=3",
                              gameOver, invulnerable, livesCount);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      reach_one_life();
      playerHit = 1'b1; extraLife = 1'b1;
      tick();
      playerHit = 1'b0; extraLife = 1'b0;
      checks++;
      if (livesCount !== 3'd1 || invulnerable !== 1'b1 || gameOver !== 1'b0) begin
         failures++; $display("FAIL hit_plus_extra got lives=%0d inv=%b go=%b exp lives=1 inv=1 go=0",
                              livesCount, invulnerable, gameOver);
      end
   endtask

   task automatic test_reset_mid_invuln();
      new_game();
      hit_pulse();
      sof(50);
      checks++;
      if (dut.inv_cnt_q !== 8'd40 || invulnerable !== 1'b1) begin
         failures++; $display("FAIL pre_reset_cnt got=%0d inv=%b exp cnt=40 inv=1", dut.inv_cnt_q, invulnerable);
      end
      #2 resetN = 1'b0;
      #1;
      checks++;
      if (invulnerable !== 1'b0 || livesCount !== 3'd3 || dut.inv_cnt_q !== 8'd0 || gameOver !== 1'b0) begin
         failures++; $display("FAIL async_reset got inv=%b lives=%0d cnt=%0d exp inv=0 lives=3 cnt=0",
                              invulnerable, livesCount, dut.inv_cnt_q);
      end
      tick();
      resetN = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_scan();
      test_hit_hold();
      test_invuln();
      test_extra_sat();
      test_game_over();
      test_back_to_back();
      test_reset_mid_invuln();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
